// File: rtl/pc_next_sel.sv
// Next-PC selection with NSRC prioritised redirect sources, stall hold and a one-entry
// pending-redirect buffer. Define PCSEL_ALIGN_CHECK_EN to trap misaligned redirect targets.
module pc_next_sel #(
  parameter int               WIDTH     = 32,
  parameter int               NSRC      = 4,
  parameter int               INC       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h00001000,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h00000080,
  localparam int              SELW      = $clog2(NSRC+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [NSRC-1:0]       redir_valid,
  input  logic [NSRC*WIDTH-1:0] redir_target,
  output logic [WIDTH-1:0]      pc,
  output logic [SELW-1:0]       pc_sel,
  output logic                  pending,
  output logic                  misalign
);

  typedef enum logic {EMPTY, FULL} buf_state_t;

  buf_state_t       buf_state;
  logic [SELW-1:0]  buf_sel;
  logic [WIDTH-1:0] buf_target;
  logic             misalign_q;

  logic             new_valid;
  logic [SELW-1:0]  new_sel;
  logic [WIDTH-1:0] new_target;
  logic             take_new;
  logic             cand_valid;
  logic [SELW-1:0]  cand_sel;
  logic [WIDTH-1:0] cand_target;
  logic             trap_hit;

  // Buffer and candidates carry the source index already offset by one, i.e. the pc_sel code.
  always_comb begin
    new_valid  = 1'b0;
    new_sel    = '0;
    new_target = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (redir_valid[i]) begin
        new_valid  = 1'b1;
        new_sel    = SELW'(i + 1);
        new_target = redir_target[i*WIDTH +: WIDTH];
      end
    end
    take_new    = new_valid && ((buf_state == EMPTY) || (new_sel >= buf_sel));
    cand_valid  = take_new || (buf_state == FULL);
    cand_sel    = take_new ? new_sel : buf_sel;
    cand_target = take_new ? new_target : buf_target;
`ifdef PCSEL_ALIGN_CHECK_EN
    trap_hit    = cand_valid && (cand_target[1:0] != 2'b00);
`else
    trap_hit    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_VEC;
      pc_sel     <= '0;
      buf_state  <= EMPTY;
      buf_sel    <= '0;
      buf_target <= '0;
      misalign_q <= 1'b0;
    end else if (stall) begin
      misalign_q <= 1'b0;
      // Equal or higher index overwrites; a lower-priority redirect is dropped.
      if (take_new) begin
        buf_state  <= FULL;
        buf_sel    <= new_sel;
        buf_target <= new_target;
      end
    end else begin
      buf_state  <= EMPTY;
      misalign_q <= trap_hit;
      if (trap_hit) begin
        pc     <= TRAP_VEC;
        pc_sel <= SELW'(NSRC + 1);
      end else if (cand_valid) begin
        pc     <= cand_target;
        pc_sel <= cand_sel;
      end else begin
        pc     <= pc + WIDTH'(INC);
        pc_sel <= '0;
      end
    end
  end

  assign pending  = (buf_state == FULL);
  assign misalign = misalign_q;

endmodule

// File: doc/pc_next_sel.md
# pc_next_sel

Parametrised next-PC selection unit for the Lab 2 datapath. It generalises the five-input PC mux (sequential, jalr, branch, jump, exception) to NSRC prioritised redirect sources and owns the PC register. It also adds stall handling, a one-entry pending-redirect buffer so a redirect that arrives during a stall is never lost, and an optional target-alignment trap. It sits between the branch/jump/exception resolution logic and instruction fetch.

## Interface
- WIDTH, 32, address width in bits.
- NSRC, 4, number of redirect sources; index NSRC-1 has highest priority (the exception source sits there).
- INC, 4, sequential increment.
- RESET_VEC, 32'h00001000, PC value after reset.
- TRAP_VEC, 32'h00000080, misalignment trap target; used only when PCSEL_ALIGN_CHECK_EN is defined.
- Localparam SELW = $clog2(NSRC+1).
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- stall  in  1  hold the PC this cycle.
- redir_valid  in  NSRC  bit i asserts source i for this cycle only.
- redir_target  in  NSRC*WIDTH  target of source i at [i*WIDTH +: WIDTH].
- pc  out  WIDTH  current fetch PC, registered.
- pc_sel  out  SELW  origin of current pc: 0 = sequential or reset, i+1 = redirect source i, SELW'(NSRC+1) = alignment trap.
- pending  out  1  a redirect is buffered and waiting for stall to drop.
- misalign  out  1  registered one-cycle pulse on an alignment trap; constant 0 when the macro is not defined.

## Operation
- Candidate: the highest-index asserted bit of redir_valid, combined with the buffered pending entry. The entry with the higher source index wins. On a tie, the new redirect wins.
- Not stalled:
  - If a candidate exists, pc <= candidate target and pc_sel <= candidate index + 1.
  - Otherwise pc <= pc + INC, truncated to WIDTH (wraps modulo 2^WIDTH), and pc_sel <= 0.
  - The pending buffer clears in the same cycle.
- Stalled:
  - pc and pc_sel hold.
  - If a redirect is asserted and its index is >= the buffered index (or the buffer is empty), the buffer loads that target and index and pending <= 1.
  - A lower-priority redirect while a higher one is buffered is dropped.
- Pending-buffer states:
  - EMPTY -> FULL on a stalled cycle with any redir_valid bit set.
  - FULL -> FULL on a stalled cycle: overwritten by a redirect of equal or higher index, otherwise held.
  - FULL -> EMPTY on the first non-stalled cycle.
- Reset (any cycle, including mid-stall with pending set):
  - pc <= RESET_VEC, pc_sel <= 0, pending <= 0, misalign <= 0.
  - Buffer contents are discarded.

## Timing
- One-cycle latency: a redirect sampled at edge N appears on pc after edge N.
- A redirect buffered during a stall appears on pc one cycle after the cycle stall is sampled low.
- stall and redirect asserted together with an empty buffer: pc holds, and pending reads 1 after that edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- redir_valid bits are single-cycle qualifiers. A source must not rely on holding its bit across a stall; the buffer does that.

## Configuration
- PCSEL_ALIGN_CHECK_EN defined:
  - On a non-stalled cycle where the winning redirect target has bits [1:0] != 0, pc <= TRAP_VEC, pc_sel <= NSRC+1 and misalign pulses 1 for one cycle.
  - Sequential increments are not checked.
  - A misaligned target buffered during a stall is checked when it is consumed.
- PCSEL_ALIGN_CHECK_EN not defined:
  - Targets load unchecked, misalign is tied 0, and the pc_sel value NSRC+1 never occurs.

## Test plan
- Reset, then run 3 free cycles -> pc = 00001000, 00001004, 00001008, 0000100C; pc_sel = 0; pending = 0.
- pc = 00001018; assert sources 0, 1 and 3 together with targets 00007612, 00008870 and 20100000 -> pc = 20100000, pc_sel = 4.
- stall = 1; pulse source 1 = 00008870, then source 0 = 00204034 on the next cycle; release stall -> pc holds during the stall, pending = 1, then pc = 00008870 and pending = 0.
- Stalled with source 2 buffered; on the unstall cycle pulse source 3 = 00000100 -> pc = 00000100, pc_sel = 4.
- WIDTH = 32, pc = FFFFFFFC, no redirect -> pc = 00000000.
- Alignment case:
  - With PCSEL_ALIGN_CHECK_EN defined: source 0 = 00000045 -> pc = 00000080, misalign pulses for one cycle, pc_sel = NSRC+1.
  - Without the macro: pc = 00000045, misalign = 0.
  - Then assert reset while pending = 1 -> pc = 00001000, pending = 0.
